// File: rtl/bit_isolate_pkg.sv
// Shared types for the bit-isolating serializer: FSM state encoding and
// word-ordering mode constants.
package bit_isolate_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   localparam logic MODE_LSB = 1'b0;
   localparam logic MODE_MSB = 1'b1;

endpackage

// File: rtl/bit_isolate_serializer_if.sv
// Handshake bundle between a word producer / beat consumer and the serializer.
// The slave modport is the serializer's view.
interface bit_isolate_serializer_if #(
   parameter int WIDTH = 32
);
   localparam int IDXW = $clog2(WIDTH);

   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_data;
   logic              in_mode;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_onehot;
   logic [IDXW-1:0]   out_index;
   logic              out_last;
   logic              out_zero;
   logic [IDXW:0]     out_seq;

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_onehot, out_index, out_last, out_zero, out_seq
   );

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_onehot, out_index, out_last, out_zero, out_seq
   );

endinterface

// File: rtl/bit_isolate_core.sv
// Combinational bit isolator: picks the lowest or highest set bit of the
// residue, encodes its position and flags whether it is the final one.
module bit_isolate_core
   import bit_isolate_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int IDXW  = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] i_residue,
   input  logic             i_mode,
   output logic [WIDTH-1:0] o_onehot,
   output logic [IDXW-1:0]  o_index,
   output logic             o_last
);

   logic [WIDTH-1:0] w_lsb;
   logic [WIDTH-1:0] w_msb;

   assign w_lsb = i_residue & (-i_residue);

   // A bit is the MSB when it is set and nothing above it is.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_msb
      if (gi == WIDTH - 1) begin : g_top
         assign w_msb[gi] = i_residue[gi];
      end else begin : g_rest
         assign w_msb[gi] = i_residue[gi] & ~(|i_residue[WIDTH-1:gi+1]);
      end
   end

   assign o_onehot = (i_mode == MODE_MSB) ? w_msb : w_lsb;

   always_comb begin
      o_index = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (o_onehot[i]) begin
            o_index = o_index | IDXW'(i);
         end
      end
   end

   assign o_last = ((i_residue & ~o_onehot) == '0);

endmodule

// File: rtl/bit_isolate_serializer.sv
// Accepts a word and emits its set bits one per beat as one-hot/index pairs,
// lowest-first or highest-first; an all-zero word yields a single zero beat.
module bit_isolate_serializer
   import bit_isolate_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   bit_isolate_serializer_if.slave  bus
);

   localparam int IDXW = $clog2(WIDTH);
   localparam logic [IDXW:0] SEQ_ONE = {{IDXW{1'b0}}, 1'b1};

   state_t            r_state;
   state_t            w_state_next;
   logic [WIDTH-1:0]  r_residue;
   logic [WIDTH-1:0]  w_residue_next;
   logic              r_mode;
   logic              w_mode_next;
   logic [IDXW:0]     r_seq;
   logic [IDXW:0]     w_seq_next;
   logic              r_zero;
   logic              w_zero_next;

   logic [WIDTH-1:0]  w_onehot;
   logic [IDXW-1:0]   w_index;
   logic              w_core_last;
   logic              w_emit;
   logic              w_last;
   logic              w_fire_out;
   logic              w_in_ready;
   logic              w_accept;

   bit_isolate_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .i_residue (r_residue),
      .i_mode    (r_mode),
      .o_onehot  (w_onehot),
      .o_index   (w_index),
      .o_last    (w_core_last)
   );

   assign w_emit     = (r_state == ST_EMIT);
   assign w_last     = w_emit & w_core_last;
   assign w_fire_out = w_emit & bus.out_ready;
   // Accepting while the final beat drains keeps words back-to-back.
   assign w_in_ready = ~w_emit | (w_fire_out & w_last);
   assign w_accept   = bus.in_valid & w_in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_residue <= '0;
         r_mode    <= MODE_LSB;
         r_seq     <= '0;
         r_zero    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_residue <= w_residue_next;
         r_mode    <= w_mode_next;
         r_seq     <= w_seq_next;
         r_zero    <= w_zero_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_residue_next = r_residue;
      w_mode_next    = r_mode;
      w_seq_next     = r_seq;
      w_zero_next    = r_zero;

      unique case (r_state)
         ST_IDLE: begin
            w_state_next = ST_IDLE;
         end
         ST_EMIT: begin
            if (w_fire_out) begin
               w_residue_next = r_residue & ~w_onehot;
               w_seq_next     = r_seq + SEQ_ONE;
               if (w_last) begin
                  w_state_next = ST_IDLE;
                  w_zero_next  = 1'b0;
               end
            end
         end
      endcase

      if (w_accept) begin
         w_state_next   = ST_EMIT;
         w_residue_next = bus.in_data;
         w_mode_next    = bus.in_mode;
         w_seq_next     = '0;
         w_zero_next    = (bus.in_data == '0);
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = w_emit;
   assign bus.out_onehot = w_onehot;
   assign bus.out_index  = w_index;
   assign bus.out_last   = w_last;
   assign bus.out_zero   = r_zero & w_emit;
   assign bus.out_seq    = r_seq;

endmodule

// File: tb/tb_bit_isolate_serializer.sv
// Bench for bit_isolate_serializer: a queue of expected beats built from the
// set-bit positions of each accepted word is compared every cycle.
module tb_bit_isolate_serializer;

   localparam int W  = 32;
   localparam int IW = $clog2(W);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bit_isolate_serializer_if #(.WIDTH(W)) bif ();

   bit_isolate_serializer #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   typedef struct {
      logic [W-1:0]  onehot;
      logic [IW-1:0] idx;
      bit            last;
      bit            zero;
      logic [IW:0]   seq;
   } beat_t;

   beat_t q[$];
   int    n_checks   = 0;
   int    n_errors   = 0;
   int    beats_seen = 0;

   // Expected beats: set-bit positions in ascending (mode 0) or descending order.
   task automatic push_word(input logic [W-1:0] d, input logic m);
      int    pos[$];
      beat_t b;
      int    p;
      for (int i = 0; i < W; i++) if (d[i]) pos.push_back(i);
      if (m) pos.reverse();
      if (pos.size() == 0) begin
         b.onehot = '0; b.idx = '0; b.last = 1'b1; b.zero = 1'b1; b.seq = '0;
         q.push_back(b);
      end else begin
         for (int k = 0; k < pos.size(); k++) begin
            p = pos[k];
            b.onehot = '0;
            b.onehot[p] = 1'b1;
            b.idx  = p[IW-1:0];
            b.last = (k == pos.size() - 1);
            b.zero = 1'b0;
            b.seq  = k[IW:0];
            q.push_back(b);
         end
      end
      $display("word accepted data=%h mode=%0d beats=%0d", d, m, (pos.size() == 0) ? 1 : pos.size());
   endtask

   task automatic cycle(input logic v, input logic [W-1:0] d, input logic m, input logic r);
      bit exp_valid, exp_rdy, fire, acc;
      @(negedge clk);
      bif.in_valid  = v;
      bif.in_data   = d;
      bif.in_mode   = m;
      bif.out_ready = r;
      #1;
      exp_valid = (q.size() != 0);
      if (exp_valid) exp_rdy = r && q[0].last;
      else           exp_rdy = 1'b1;
      n_checks++;
      if (bif.out_valid !== exp_valid) begin
         n_errors++;
         $display("FAIL out_valid: got %b need %b", bif.out_valid, exp_valid);
      end
      n_checks++;
      if (bif.in_ready !== exp_rdy) begin
         n_errors++;
         $display("FAIL in_ready: got %b need %b", bif.in_ready, exp_rdy);
      end
      if (exp_valid) begin
         n_checks++;
         if (bif.out_onehot !== q[0].onehot || bif.out_index !== q[0].idx ||
             bif.out_last !== q[0].last || bif.out_zero !== q[0].zero || bif.out_seq !== q[0].seq) begin
            n_errors++;
            $display("FAIL beat: got onehot=%h idx=%0d last=%b zero=%b seq=%0d need onehot=%h idx=%0d last=%b zero=%b seq=%0d",
                     bif.out_onehot, bif.out_index, bif.out_last, bif.out_zero, bif.out_seq,
                     q[0].onehot, q[0].idx, q[0].last, q[0].zero, q[0].seq);
         end
      end
      fire = exp_valid && r;
      acc  = v && exp_rdy;
      @(posedge clk);
      if (fire) begin
         $display("beat idx=%0d seq=%0d last=%b zero=%b", q[0].idx, q[0].seq, q[0].last, q[0].zero);
         void'(q.pop_front());
         beats_seen++;
      end
      if (acc) push_word(d, m);
   endtask

   task automatic drain(input int max_cycles);
      int n = 0;
      while (q.size() != 0 && n < max_cycles) begin
         cycle(1'b0, $urandom, 1'($urandom_range(0, 1)), 1'b1);
         n++;
      end
      n_checks++;
      if (q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d beats left need 0", q.size());
         q.delete();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bif.in_valid  = 1'b0;
      bif.out_ready = 1'b0;
      @(posedge clk);
      q.delete();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (bif.out_valid !== 1'b0 || bif.out_onehot !== '0 || bif.out_index !== '0 ||
          bif.out_last !== 1'b0 || bif.out_zero !== 1'b0 || bif.out_seq !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: got valid=%b onehot=%h idx=%0d last=%b zero=%b seq=%0d need all zero",
                  bif.out_valid, bif.out_onehot, bif.out_index, bif.out_last, bif.out_zero, bif.out_seq);
      end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (bif.in_ready !== 1'b1 || bif.out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_release: got in_ready=%b out_valid=%b need 1 0", bif.in_ready, bif.out_valid);
      end
   endtask

   task automatic test_zero_word();
      int base = beats_seen;
      cycle(1'b1, 32'h0000_0000, 1'b0, 1'b1);
      drain(10);
      n_checks++;
      if (beats_seen - base !== 1) begin
         n_errors++;
         $display("FAIL zero_word_beats: got %0d need 1", beats_seen - base);
      end
   endtask

   task automatic test_order(input logic m);
      int base = beats_seen;
      cycle(1'b1, 32'h8000_0011, m, 1'b1);
      drain(10);
      n_checks++;
      if (beats_seen - base !== 3) begin
         n_errors++;
         $display("FAIL order_beats mode=%0d: got %0d need 3", m, beats_seen - base);
      end
   endtask

   task automatic test_stall();
      int base = beats_seen;
      cycle(1'b1, 32'h8000_0011, 1'b0, 1'b1);
      cycle(1'b0, $urandom, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, $urandom, 1'b1, 1'b0);
      cycle(1'b0, $urandom, 1'b1, 1'b1);
      drain(10);
      n_checks++;
      if (beats_seen - base !== 3) begin
         n_errors++;
         $display("FAIL stall_beats: got %0d need 3", beats_seen - base);
      end
   endtask

   task automatic test_back_to_back();
      int base;
      cycle(1'b1, 32'h0000_0003, 1'b0, 1'b1);
      base = beats_seen;
      cycle(1'b1, 32'h0000_0004, 1'b0, 1'b1);
      cycle(1'b1, 32'h0000_0004, 1'b0, 1'b1);
      cycle(1'b0, $urandom, 1'b0, 1'b1);
      n_checks++;
      if (beats_seen - base !== 3 || q.size() != 0) begin
         n_errors++;
         $display("FAIL back_to_back: got %0d beats in 3 cycles (%0d pending) need 3 (0)", beats_seen - base, q.size());
      end
      drain(10);
   endtask

   task automatic test_reset_midword();
      int base;
      cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b0, $urandom, 1'b1, 1'b1);
      do_reset();
      n_checks++;
      if (bif.out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL midword_reset_valid: got %b need 0", bif.out_valid);
      end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (bif.in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL midword_reset_ready: got %b need 1", bif.in_ready);
      end
      base = beats_seen;
      cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
      drain(40);
      n_checks++;
      if (beats_seen - base !== 32) begin
         n_errors++;
         $display("FAIL all_ones_beats: got %0d need 32", beats_seen - base);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] d;
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 4))
            0:       d = '0;
            1:       d = '1;
            2:       d = $urandom & $urandom & $urandom;
            3:       d = 32'h1 << $urandom_range(0, 31);
            default: d = $urandom;
         endcase
         cycle(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      end
      drain(100);
   endtask

   initial begin
      bif.in_valid  = 1'b0;
      bif.in_data   = '0;
      bif.in_mode   = 1'b0;
      bif.out_ready = 1'b0;
      test_reset();
      test_zero_word();
      test_order(1'b0);
      test_order(1'b1);
      test_stall();
      test_back_to_back();
      test_reset_midword();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/bit_isolate_serializer.md
BIT_ISOLATE_SERIALIZER -- requirements
Module: bit_isolate_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: input word width, legal values 2..64.
REQ-002 SHALL have derived constant IDXW = clog2(WIDTH), the bit-index width.
REQ-003 SHALL have ports exactly as listed in REQ-004 to REQ-016; one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  in_data and in_mode are valid.
REQ-007 in_ready  output  1  block accepts the word this cycle.
REQ-008 in_data  input  WIDTH  word to decompose.
REQ-009 in_mode  input  1  0 = lowest set bit first; 1 = highest set bit first.
REQ-010 out_valid  output  1  output beat is valid.
REQ-011 out_ready  input  1  consumer takes the beat.
REQ-012 out_onehot  output  WIDTH  isolated bit (one-hot), or zero.
REQ-013 out_index  output  IDXW  position of the isolated bit.
REQ-014 out_last  output  1  final beat of the current word.
REQ-015 out_zero  output  1  accepted word was all-zero.
REQ-016 out_seq  output  IDXW+1  beat number within the word, starting at 0.

Function
REQ-017 SHALL use a two-state FSM: IDLE (no word held) and EMIT (residue register non-empty, or zero-word beat pending).
REQ-018 in_ready SHALL be 1 in IDLE, and 1 in EMIT only when out_valid & out_ready & out_last.
REQ-019 On accept (in_valid & in_ready), residue SHALL load in_data, mode SHALL latch in_mode, out_seq SHALL clear to 0, and the state SHALL become EMIT.
REQ-020 out_valid SHALL be 1 exactly when the state is EMIT; first beat appears the cycle after accept (latency 1).
REQ-021 Mode 0: out_onehot SHALL equal residue & -residue. Mode 1: out_onehot SHALL be the most significant set bit of residue.
REQ-022 out_index SHALL be the binary position of the out_onehot bit.
REQ-023 out_last SHALL be 1 when residue with the isolated bit removed is zero.
REQ-024 On out_valid & out_ready, the isolated bit SHALL be cleared from residue and out_seq SHALL increment; after a last beat the state SHALL return to IDLE, unless a new word is accepted the same cycle (no bubble).
REQ-025 Zero word: exactly one beat SHALL be emitted with out_onehot=0, out_index=0, out_zero=1, out_last=1; out_zero SHALL be 0 on all other beats.
REQ-026 While out_valid & !out_ready, all out_* SHALL hold stable.
REQ-027 in_mode and in_data SHALL be ignored when not accepted; mode SHALL not change mid-word.
REQ-028 The number of beats for a word SHALL equal max(1, popcount(in_data)); an all-ones word SHALL emit WIDTH beats, with out_seq reaching WIDTH-1.

Reset
REQ-029 On rst_n=0 at the clock edge: state=IDLE, residue=0, out_valid=0, out_onehot=0, out_index=0, out_last=0, out_zero=0, out_seq=0.
REQ-030 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-031 Reset mid-word SHALL discard the residue; out_valid=0 in the cycle after the reset edge, and no partial beats resume.

Structure
REQ-032 Package bit_isolate_pkg SHALL hold the FSM state enum and the mode encoding constants (MODE_LSB=0, MODE_MSB=1).
REQ-033 Sub-module bit_isolate_core SHALL be purely combinational (residue, mode -> onehot, index, last), parametrised by WIDTH.
REQ-034 All registers SHALL be in the top level; there SHALL be no combinational path from in_valid to out_*.

Verification (WIDTH=32)
REQ-035 in_data=0x00000000, mode 0 -> single beat: onehot=0, zero=1, last=1, seq=0.
REQ-036 in_data=0x80000011, mode 0, out_ready=1 -> beats (0x00000001, idx 0), (0x00000010, idx 4), (0x80000000, idx 31, last); seq 0,1,2.
REQ-037 Same word, mode 1 -> index order 31, 4, 0; last on idx 0.
REQ-038 Same as REQ-036 with out_ready=0 for 3 cycles during beat 1 -> beat 1 held unchanged 4 cycles; total 3 beats, none lost or duplicated.
REQ-039 Words 0x3 then 0x4 presented back-to-back, out_ready=1 -> beats idx 0, 1(last), 2(last) on consecutive cycles with no bubble.
REQ-040 0xFFFFFFFF, with rst_n=0 asserted after beat 5 -> out_valid=0 next cycle and in_ready=1 after release; then all-ones word again -> 32 beats, seq 0..31.
